// File: rtl/bcd_pkg.sv
// BCD nibble type, limits and sanitising helper shared with the seven-segment decoder stage.
// Pure declarations: no latency, no backpressure.
package bcd_pkg;
  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  function automatic bcd_t bcd_sanitize(input bcd_t nibble);
    return (nibble > BCD_MAX) ? '0 : nibble;
  endfunction
endpackage

// File: rtl/bcd_digit_cell.sv
// One decade of the BCD counter; cells chain through inc_in/carry_out (carry is combinational).
// Latency: q updates 1 cycle after clr/load/inc_in are sampled. No backpressure.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc_in,
  input  logic clr,
  input  logic load,
  input  bcd_t load_d,
  output bcd_t q,
  output logic carry_out
);

  bcd_t q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = bcd_sanitize(load_d);
    end else if (inc_in) begin
      q_d = (q_q == BCD_MAX) ? '0 : q_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q         = q_q;
  assign carry_out = inc_in && (q_q == BCD_MAX);

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD event counter with multiplexed display scan; LEADING_ZERO_BLANK_EN enables leading-zero blanking.
// Latency: count 1 cycle; binary_out/digit_sel registered, follow count 1 cycle later. No backpressure.
module bcd_scan_counter
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cnt_en,
  input  logic                        clr,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_val,
  output logic [BCD_W*NUM_DIGITS-1:0] count_val,
  output logic                        carry_out,
  output logic [BCD_W-1:0]            binary_out,
  output logic [NUM_DIGITS-1:0]       digit_sel
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [NUM_DIGITS-1:0] SEL_RST = {{(NUM_DIGITS-1){1'b1}}, 1'b0};

  logic [NUM_DIGITS:0]               inc;
  logic [NUM_DIGITS-1:0][BCD_W-1:0]  digit_q;

  assign inc[0] = cnt_en;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .inc_in    (inc[g]),
      .clr       (clr),
      .load      (load),
      .load_d    (load_val[g*BCD_W +: BCD_W]),
      .q         (digit_q[g]),
      .carry_out (inc[g+1])
    );
  end

  assign count_val = digit_q;

  // Cell carries ignore clr/load, so the wrap pulse is gated here.
  logic carry_q, carry_d;
  assign carry_d = !clr && !load && inc[NUM_DIGITS];

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [BCD_W-1:0]      bin_q, bin_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0] blank;

  always_comb begin
    blank = '0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      blank[k] = 1'b1;
      for (int j = k; j < NUM_DIGITS; j++) begin
        if (digit_q[j] != '0) blank[k] = 1'b0;
      end
    end
  end
`endif

  // Outputs are computed from the next index so digit_sel and binary_out switch together.
  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV-1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(NUM_DIGITS-1)) ? '0 : idx_q + IW'(1);
    end
    sel_d = ~(NUM_DIGITS'(1) << idx_d);
    bin_d = digit_q[idx_d];
`ifdef LEADING_ZERO_BLANK_EN
    if (blank[idx_d]) begin
      sel_d = '1;
      bin_d = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
      presc_q <= '0;
      idx_q   <= '0;
      bin_q   <= '0;
      sel_q   <= SEL_RST;
    end else begin
      carry_q <= carry_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      bin_q   <= bin_d;
      sel_q   <= sel_d;
    end
  end

  assign carry_out  = carry_q;
  assign binary_out = bin_q;
  assign digit_sel  = sel_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench for bcd_scan_counter (NUM_DIGITS=4, SCAN_DIV=4); build with or without LEADING_ZERO_BLANK_EN.
module tb_bcd_scan_counter;
  localparam int N  = 4;
  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst, cnt_en, clr, load;
  logic [15:0] load_val, count_val;
  logic        carry_out;
  logic [3:0]  binary_out, digit_sel;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [15:0] cnt; logic cy; } cexp_t;
  typedef struct { logic [3:0] sel; logic [3:0] bin; } sexp_t;
  typedef struct { logic e, c, l; logic [15:0] v; logic [15:0] cnt; logic cy; } cstep_t;

  cexp_t cq[$];
  sexp_t sq[$];

  bcd_scan_counter #(.NUM_DIGITS(N), .SCAN_DIV(SD)) dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_en     (cnt_en),
    .clr        (clr),
    .load       (load),
    .load_val   (load_val),
    .count_val  (count_val),
    .carry_out  (carry_out),
    .binary_out (binary_out),
    .digit_sel  (digit_sel)
  );

  always #5 clk = ~clk;

  // Expected display for a given count and scan slot.
  function automatic sexp_t exp_scan(input logic [15:0] c, input int s);
    sexp_t       r;
    logic [15:0] sh;
    r.sel    = 4'b1111;
    r.sel[s] = 1'b0;
    sh       = c >> (4 * s);
    r.bin    = sh[3:0];
`ifdef LEADING_ZERO_BLANK_EN
    if (s != 0 && sh == 16'h0000) begin
      r.sel = 4'b1111;
      r.bin = 4'h0;
    end
`endif
    return r;
  endfunction

  // Called on a falling edge: apply inputs, return on the next falling edge.
  task automatic drive(input logic e, input logic c, input logic l, input logic [15:0] v);
    cnt_en   = e;
    clr      = c;
    load     = l;
    load_val = v;
    @(negedge clk);
  endtask

  task automatic align_slot0(output bit ok);
    logic [3:0] prev;
    cnt_en = 1'b0;
    clr    = 1'b0;
    load   = 1'b0;
    ok     = 1'b0;
    prev   = digit_sel;
    for (int i = 0; i < 4 * SD * N; i++) begin
      @(negedge clk);
      if (prev != 4'b1110 && digit_sel == 4'b1110) begin
        ok = 1'b1;
        break;
      end
      prev = digit_sel;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (count_val !== 16'h0000 || carry_out !== 1'b0 || binary_out !== 4'h0 || digit_sel !== 4'b1110) begin
      errors++;
      $display("FAIL reset_init: count=%h carry=%b bin=%h sel=%b, expected 0000 0 0 1110",
               count_val, carry_out, binary_out, digit_sel);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 16'h1234);
    repeat (6) drive(1'b0, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (count_val !== 16'h1234) begin
      errors++;
      $display("FAIL reset_preload: count=%h, expected 1234", count_val);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (count_val !== 16'h0000 || carry_out !== 1'b0 || binary_out !== 4'h0 || digit_sel !== 4'b1110) begin
      errors++;
      $display("FAIL reset_async: count=%h carry=%b bin=%h sel=%b, expected 0000 0 0 1110",
               count_val, carry_out, binary_out, digit_sel);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      logic [3:0] exp_sel;
      @(negedge clk);
      exp_sel = (i < 4) ? 4'b1110 : 4'b1101;
      checks++;
      if (digit_sel !== exp_sel || binary_out !== 4'h0) begin
        errors++;
        $display("FAIL reset_first_slot cycle %0d: sel=%b bin=%h, expected %b 0", i, digit_sel, binary_out, exp_sel);
      end
    end
  endtask

  task automatic test_ripple();
    cstep_t t [10] = '{
      '{1'b0, 1'b0, 1'b1, 16'h0199, 16'h0199, 1'b0},
      '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0200, 1'b0},
      '{1'b0, 1'b0, 1'b1, 16'h9999, 16'h9999, 1'b0},
      '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1},
      '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0},
      '{1'b0, 1'b0, 1'b1, 16'h0998, 16'h0998, 1'b0},
      '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0999, 1'b0},
      '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h1000, 1'b0},
      '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h1001, 1'b0},
      '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h1001, 1'b0}
    };
    foreach (t[i]) begin
      cexp_t e;
      cq.push_back('{t[i].cnt, t[i].cy});
      drive(t[i].e, t[i].c, t[i].l, t[i].v);
      e = cq.pop_front();
      checks++;
      if (count_val !== e.cnt || carry_out !== e.cy) begin
        errors++;
        $display("FAIL ripple step %0d: count=%h carry=%b, expected %h %b", i, count_val, carry_out, e.cnt, e.cy);
      end
    end
  endtask

  task automatic test_priority();
    cstep_t t [6] = '{
      '{1'b1, 1'b1, 1'b1, 16'h1234, 16'h0000, 1'b0},
      '{1'b1, 1'b0, 1'b1, 16'h1234, 16'h1234, 1'b0},
      '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 1'b0},
      '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h1235, 1'b0},
      '{1'b0, 1'b0, 1'b1, 16'h9999, 16'h9999, 1'b0},
      '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0}
    };
    foreach (t[i]) begin
      cexp_t e;
      cq.push_back('{t[i].cnt, t[i].cy});
      drive(t[i].e, t[i].c, t[i].l, t[i].v);
      e = cq.pop_front();
      checks++;
      if (count_val !== e.cnt || carry_out !== e.cy) begin
        errors++;
        $display("FAIL priority step %0d: count=%h carry=%b, expected %h %b", i, count_val, carry_out, e.cnt, e.cy);
      end
    end
  endtask

  task automatic test_sanitize();
    cstep_t t [3] = '{
      '{1'b0, 1'b0, 1'b1, 16'h1A3F, 16'h1030, 1'b0},
      '{1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0},
      '{1'b0, 1'b0, 1'b1, 16'h9A09, 16'h9009, 1'b0}
    };
    foreach (t[i]) begin
      cexp_t e;
      cq.push_back('{t[i].cnt, t[i].cy});
      drive(t[i].e, t[i].c, t[i].l, t[i].v);
      e = cq.pop_front();
      checks++;
      if (count_val !== e.cnt || carry_out !== e.cy) begin
        errors++;
        $display("FAIL sanitize step %0d: count=%h carry=%b, expected %h %b", i, count_val, carry_out, e.cnt, e.cy);
      end
    end
  endtask

  task automatic test_scan();
    bit ok;
    drive(1'b0, 1'b0, 1'b1, 16'h4321);
    align_slot0(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL scan_align: slot 0 start not seen, sel=%b, expected 1110", digit_sel);
      return;
    end
    for (int i = 0; i < 20; i++) sq.push_back(exp_scan(16'h4321, (i / SD) % N));
    for (int i = 0; i < 20; i++) begin
      sexp_t e;
      if (i > 0) @(negedge clk);
      e = sq.pop_front();
      checks++;
      if (digit_sel !== e.sel || binary_out !== e.bin) begin
        errors++;
        $display("FAIL scan cycle %0d: sel=%b bin=%h, expected %b %h", i, digit_sel, binary_out, e.sel, e.bin);
      end
    end
  endtask

  // Count changes mid-slot and on the slot boundary edge.
  task automatic test_midslot();
    bit     ok;
    cstep_t t [5] = '{
      '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h4322, 1'b0},
      '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h4322, 1'b0},
      '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h4322, 1'b0},
      '{1'b0, 1'b0, 1'b1, 16'h4351, 16'h4351, 1'b0},
      '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h4351, 1'b0}
    };
    sexp_t xs [5] = '{'{4'b1110, 4'h1}, '{4'b1110, 4'h2}, '{4'b1110, 4'h2}, '{4'b1101, 4'h2}, '{4'b1101, 4'h5}};
    drive(1'b0, 1'b0, 1'b1, 16'h4321);
    align_slot0(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL midslot_align: slot 0 start not seen, sel=%b, expected 1110", digit_sel);
      return;
    end
    foreach (t[i]) begin
      sexp_t e;
      cexp_t c;
      sq.push_back(xs[i]);
      cq.push_back('{t[i].cnt, t[i].cy});
      drive(t[i].e, t[i].c, t[i].l, t[i].v);
      e = sq.pop_front();
      c = cq.pop_front();
      checks++;
      if (digit_sel !== e.sel || binary_out !== e.bin || count_val !== c.cnt) begin
        errors++;
        $display("FAIL midslot step %0d: sel=%b bin=%h count=%h, expected %b %h %h",
                 i, digit_sel, binary_out, count_val, e.sel, e.bin, c.cnt);
      end
    end
  endtask

  task automatic test_blank();
    logic [15:0] vals [2] = '{16'h0042, 16'h0000};
    foreach (vals[v]) begin
      bit ok;
      drive(1'b0, 1'b0, 1'b1, vals[v]);
      align_slot0(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL blank_align %h: slot 0 start not seen, sel=%b, expected 1110", vals[v], digit_sel);
        continue;
      end
      for (int i = 0; i < SD * N; i++) sq.push_back(exp_scan(vals[v], i / SD));
      for (int i = 0; i < SD * N; i++) begin
        sexp_t e;
        if (i > 0) @(negedge clk);
        e = sq.pop_front();
        checks++;
        if (digit_sel !== e.sel || binary_out !== e.bin) begin
          errors++;
          $display("FAIL blank %h cycle %0d: sel=%b bin=%h, expected %b %h",
                   vals[v], i, digit_sel, binary_out, e.sel, e.bin);
        end
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    cnt_en   = 1'b0;
    clr      = 1'b0;
    load     = 1'b0;
    load_val = 16'h0000;
    test_reset();
    test_ripple();
    test_priority();
    test_sanitize();
    test_scan();
    test_midslot();
    test_blank();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
